// File: rtl/spdif_subframe_unpacker.sv
// Generic first-word-fall-through FIFO: head entry is always visible on out_dat.
// Latency: write at edge W is visible after edge W; pop at edge P exposes the next entry after P.
// Backpressure: in_rdy drops when full unless the same cycle pops, so a full FIFO still accepts a write-with-pop.
module sync_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_vld,
  output logic             in_rdy,
  input  logic [WIDTH-1:0] in_dat,
  output logic             out_vld,
  input  logic             out_rdy,
  output logic [WIDTH-1:0] out_dat
);
  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic [AW:0]      count;
  logic             push;
  logic             pop;

  assign out_vld = (count != '0);
  assign in_rdy  = (count != FULL_CNT) || out_rdy;
  assign push    = in_vld && in_rdy;
  assign pop     = out_vld && out_rdy;
  assign out_dat = mem[rd_ptr];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) begin
        mem[wr_ptr] <= in_dat;
        wr_ptr      <= wr_ptr + 1'b1;
      end
      if (pop) rd_ptr <= rd_ptr + 1'b1;
      if (push && !pop)      count <= count + 1'b1;
      else if (!push && pop) count <= count - 1'b1;
    end
  end
endmodule

// S/PDIF subframe unpacker: parity/preamble checking, channel-status capture, sample FIFO.
// Latency: 2 clk from the 28th bit to a visible sample; error pulses 1 clk after that bit.
// Backpressure: sample_ready stalls the FIFO; a good subframe meeting a full FIFO is dropped and sets overflow.
module spdif_subframe_unpacker #(
  parameter int SAMPLE_WIDTH = 24,
  parameter int FIFO_DEPTH   = 8
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    sof,
  input  logic [1:0]              pre_type,
  input  logic                    vin,
  input  logic                    din,
  output logic [SAMPLE_WIDTH-1:0] sample_data,
  output logic                    sample_ch,
  output logic                    sample_vbit,
  output logic [3:0]              sample_aux,
  output logic                    sample_valid,
  input  logic                    sample_ready,
  output logic [191:0]            cs_a,
  output logic [191:0]            cs_b,
  output logic                    cs_valid,
  output logic                    parity_err,
  output logic                    sync_err,
  output logic                    overflow
);
  localparam int EW = SAMPLE_WIDTH + 6;

  typedef enum logic {SEARCH, RUN} state_t;

  state_t         state;
  logic [26:0]    sr;
  logic [4:0]     bit_cnt;
  logic [7:0]     frame_idx;
  logic           cur_ch;
  logic           block_err;
  logic [191:0]   shadow_a;
  logic [191:0]   shadow_b;
  logic           wr_pend;
  logic [EW-1:0]  wr_dat;
  logic [EW-1:0]  head;
  logic           fifo_rdy;

  logic           run;
  logic           short_sf;
  logic           seq_ok;
  logic           b_good;
  logic           sof_sync;
  logic           cs_fire;
  logic           run_nx;
  logic           ch_nx;
  logic [4:0]     cnt_nx;
  logic           overrun;
  logic           bit_take;
  logic           last_bit;
  logic [27:0]    word;

  assign run = (state == RUN);

  // sof is resolved first; the bit logic below then works on the post-sof state
  always_comb begin
    short_sf = run && sof && (bit_cnt != 5'd0) && (bit_cnt != 5'd28);
    b_good   = cur_ch && (frame_idx == 8'd191);
    seq_ok   = 1'b0;
    case (pre_type)
      2'd0:    seq_ok = 1'b1;
      2'd1:    seq_ok = cur_ch && (frame_idx != 8'd191);
      2'd2:    seq_ok = !cur_ch;
      default: seq_ok = 1'b0;
    endcase
    sof_sync = run && sof && (short_sf || !seq_ok || ((pre_type == 2'd0) && !b_good));
    cs_fire  = run && sof && (pre_type == 2'd0) && b_good && !short_sf && !block_err;

    run_nx = run;
    cnt_nx = bit_cnt;
    ch_nx  = cur_ch;
    if (sof) begin
      cnt_nx = 5'd0;
      ch_nx  = (pre_type == 2'd2);
      run_nx = run ? seq_ok : (pre_type == 2'd0);
    end
    overrun  = vin && run_nx && (cnt_nx == 5'd28);
    bit_take = vin && run_nx && (cnt_nx != 5'd28);
    last_bit = bit_take && (cnt_nx == 5'd27);
    word     = {din, sr};
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= SEARCH;
      sr         <= '0;
      bit_cnt    <= '0;
      frame_idx  <= '0;
      cur_ch     <= 1'b0;
      block_err  <= 1'b0;
      shadow_a   <= '0;
      shadow_b   <= '0;
      cs_a       <= '0;
      cs_b       <= '0;
      cs_valid   <= 1'b0;
      parity_err <= 1'b0;
      sync_err   <= 1'b0;
      overflow   <= 1'b0;
      wr_pend    <= 1'b0;
      wr_dat     <= '0;
    end else begin
      state      <= (run_nx && !overrun) ? RUN : SEARCH;
      bit_cnt    <= bit_take ? (cnt_nx + 5'd1) : cnt_nx;
      cur_ch     <= ch_nx;
      cs_valid   <= cs_fire;
      sync_err   <= sof_sync || overrun;
      parity_err <= 1'b0;
      wr_pend    <= 1'b0;
      overflow   <= overflow || (wr_pend && !fifo_rdy);
      if (bit_take) sr <= word[27:1];

      if (sof && (pre_type == 2'd0)) begin
        frame_idx <= 8'd0;
        block_err <= 1'b0;
      end else if (sof_sync || overrun || (last_bit && ^word)) begin
        block_err <= 1'b1;
      end
      if (run && sof && (pre_type == 2'd1) && seq_ok) frame_idx <= frame_idx + 8'd1;

      if (cs_fire) begin
        cs_a <= shadow_a;
        cs_b <= shadow_b;
      end

      if (last_bit) begin
        if (^word) begin
          parity_err <= 1'b1;
        end else begin
          wr_pend <= 1'b1;
          wr_dat  <= {ch_nx, word[24], word[3:0], word[23 -: SAMPLE_WIDTH]};
          if (ch_nx) shadow_b[frame_idx] <= word[26];
          else       shadow_a[frame_idx] <= word[26];
        end
      end
    end
  end

  sync_fifo #(.WIDTH(EW), .DEPTH(FIFO_DEPTH)) u_fifo (
    .clk     (clk),
    .rst_n   (rst_n),
    .in_vld  (wr_pend),
    .in_rdy  (fifo_rdy),
    .in_dat  (wr_dat),
    .out_vld (sample_valid),
    .out_rdy (sample_ready),
    .out_dat (head)
  );

  assign sample_ch   = head[EW-1];
  assign sample_vbit = head[EW-2];
  assign sample_aux  = head[EW-3 -: 4];
  assign sample_data = head[SAMPLE_WIDTH-1:0];
endmodule
